// File: rtl/palette_mapper_pipe.sv
// Programmable palette colour mapper with grid overlay on index 0 and a
// frame-paced fade-out/fade-in brightness engine; fixed two-cycle latency.
module palette_mapper_pipe #(
    parameter int unsigned INDEX_W   = 4,
    parameter int unsigned COLOR_W   = 8,
    parameter int unsigned GRID_LOG2 = 3,
    parameter int unsigned FADE_W    = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [INDEX_W-1:0]     PaletteIndex,
    input  logic                   pix_valid,
    input  logic                   frame_start,
    input  logic                   pal_we,
    input  logic [INDEX_W-1:0]     pal_waddr,
    input  logic [3*COLOR_W-1:0]   pal_wdata,
    input  logic                   grid_we,
    input  logic                   fade_start,
    input  logic                   fade_dir,
    output logic                   fade_busy,
    output logic [FADE_W:0]        fade_level,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B,
    output logic                   out_valid
);

    localparam int unsigned DEPTH  = 2**INDEX_W;
    localparam int unsigned RGB_W  = 3*COLOR_W;
    localparam int unsigned LVL_W  = FADE_W + 1;
    localparam int unsigned PROD_W = COLOR_W + FADE_W + 1;
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(2**FADE_W);
    localparam logic [RGB_W-1:0] GRID_RST = RGB_W'(24'hE7CAA0);

    typedef enum logic [1:0] {IDLE, FADE_OUT, DARK, FADE_IN} fade_state_t;

    logic [RGB_W-1:0] pal [DEPTH];
    logic [RGB_W-1:0] grid_rgb;
    logic             s1_valid;
    logic [RGB_W-1:0] s1_rgb;
    logic             grid_hit_c;
    fade_state_t      state_q, state_d;
    logic [LVL_W-1:0] level_d;
    logic             unused_draw;

    assign unused_draw = &{1'b0, DrawX[9:GRID_LOG2], DrawY[9:GRID_LOG2]};

    // Game's standard colours loaded at reset
    function automatic logic [RGB_W-1:0] reset_color(input int unsigned i);
        case (i)
            0:       return RGB_W'(24'hFAF7EB);
            2:       return RGB_W'(24'h262626);
            3:       return RGB_W'(24'h079CC2);
            4:       return RGB_W'(24'hC7C42B);
            5:       return RGB_W'(24'h5B8C20);
            6:       return RGB_W'(24'h595959);
            7:       return RGB_W'(24'hFDE87D);
            8:       return RGB_W'(24'h48926A);
            9:       return RGB_W'(24'hFAF7EB);
            default: return '0;
        endcase
    endfunction

    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [LVL_W-1:0]   l);
        logic [PROD_W-1:0] p;
        p = PROD_W'(c) * PROD_W'(l);
        return COLOR_W'(p >> FADE_W);
    endfunction

    // Palette and grid colour register file; writes land at the edge
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) pal[i] <= reset_color(i);
            grid_rgb <= GRID_RST;
        end else begin
            if (pal_we)  pal[pal_waddr] <= pal_wdata;
            if (grid_we) grid_rgb       <= pal_wdata;
        end
    end

    assign grid_hit_c = (PaletteIndex == '0) &&
                        ((DrawX[GRID_LOG2-1:0] == '0) || (DrawY[GRID_LOG2-1:0] == '0));

    // Stage 1: palette lookup with grid override (reads pre-write contents)
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_rgb   <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_rgb   <= grid_hit_c ? grid_rgb : pal[PaletteIndex];
        end
    end

    // Stage 2: brightness scaling with blanking
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                VGA_R <= scale(s1_rgb[3*COLOR_W-1 -: COLOR_W], fade_level);
                VGA_G <= scale(s1_rgb[2*COLOR_W-1 -: COLOR_W], fade_level);
                VGA_B <= scale(s1_rgb[COLOR_W-1:0], fade_level);
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

    // Fade engine state and level registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            fade_level <= LVL_MAX;
            fade_busy  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fade_level <= level_d;
            fade_busy  <= (state_d == FADE_OUT) || (state_d == FADE_IN);
        end
    end

    // Fade next-state: a starting edge only changes state, never the level
    always_comb begin
        state_d = state_q;
        level_d = fade_level;
        case (state_q)
            IDLE: begin
                if (fade_start) state_d = fade_dir ? FADE_IN : FADE_OUT;
            end
            FADE_OUT: begin
                if (frame_start) begin
                    if (fade_level != '0) level_d = fade_level - LVL_W'(1);
                    if (level_d == '0) state_d = DARK;
                end
            end
            DARK: begin
                if (fade_start && fade_dir) state_d = FADE_IN;
            end
            FADE_IN: begin
                if (frame_start) begin
                    if (fade_level != LVL_MAX) level_d = fade_level + LVL_W'(1);
                    if (level_d == LVL_MAX) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_palette_mapper_pipe.sv
// Self-checking bench for palette_mapper_pipe: table vectors, directed fade and
// write sequences, and randomized traffic against a cycle-level reference model.
module tb_palette_mapper_pipe;

    logic        Clk;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic [3:0]  PaletteIndex;
    logic        pix_valid, frame_start, pal_we, grid_we, fade_start, fade_dir;
    logic [3:0]  pal_waddr;
    logic [23:0] pal_wdata;
    logic        fade_busy, out_valid;
    logic [4:0]  fade_level;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    int vectors = 0;
    int miscompares = 0;

    palette_mapper_pipe dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .PaletteIndex(PaletteIndex), .pix_valid(pix_valid), .frame_start(frame_start),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .grid_we(grid_we),
        .fade_start(fade_start), .fade_dir(fade_dir), .fade_busy(fade_busy),
        .fade_level(fade_level), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .out_valid(out_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: palette contents, one in-flight pixel, fade mode and level
    logic [23:0] m_pal [16];
    logic [23:0] m_grid;
    logic        m_s1v;
    logic [23:0] m_s1c;
    int          m_lvl;
    int          m_mode;   // 0 idle, 1 fading out, 2 dark, 3 fading in
    logic        e_v;
    logic [23:0] e_rgb;

    function automatic logic [7:0] sc(input int c, input int l);
        return 8'((c * l) / 16);
    endfunction

    task automatic model_reset();
        m_pal  = '{24'hFAF7EB, 24'h000000, 24'h262626, 24'h079CC2,
                   24'hC7C42B, 24'h5B8C20, 24'h595959, 24'hFDE87D,
                   24'h48926A, 24'hFAF7EB, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        m_grid = 24'hE7CAA0;
        m_s1v  = 1'b0;
        m_s1c  = '0;
        m_lvl  = 16;
        m_mode = 0;
        e_v    = 1'b0;
        e_rgb  = '0;
    endtask

    task automatic model_update();
        if (!Reset_n) begin
            model_reset();
            return;
        end
        e_v   = m_s1v;
        e_rgb = m_s1v ? {sc(int'(m_s1c[23:16]), m_lvl), sc(int'(m_s1c[15:8]), m_lvl),
                         sc(int'(m_s1c[7:0]), m_lvl)} : 24'h0;
        m_s1v = pix_valid;
        if (PaletteIndex == 0 && (DrawX % 8 == 0 || DrawY % 8 == 0)) m_s1c = m_grid;
        else m_s1c = m_pal[PaletteIndex];
        if (pal_we)  m_pal[pal_waddr] = pal_wdata;
        if (grid_we) m_grid = pal_wdata;
        if (m_mode == 1 && frame_start) begin
            if (m_lvl > 0) m_lvl--;
            if (m_lvl == 0) m_mode = 2;
        end else if (m_mode == 3 && frame_start) begin
            if (m_lvl < 16) m_lvl++;
            if (m_lvl == 16) m_mode = 0;
        end else if (fade_start && (m_mode == 0 || m_mode == 2)) begin
            if (fade_dir) m_mode = 3;
            else if (m_mode == 0) m_mode = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model advances with the applied inputs, then all outputs compared
    task automatic step();
        logic mb;
        @(posedge Clk);
        #1;
        model_update();
        mb = (m_mode == 1) || (m_mode == 3);
        chk("cycle", {1'b0, out_valid, fade_busy, fade_level, VGA_R, VGA_G, VGA_B},
                     {1'b0, e_v, mb, 5'(m_lvl), e_rgb});
    endtask

    task automatic set_idle();
        pix_valid = 0; frame_start = 0; pal_we = 0; grid_we = 0; fade_start = 0;
        fade_dir = 0; PaletteIndex = 4'd1; DrawX = 10'd1; DrawY = 10'd1;
        pal_waddr = 0; pal_wdata = 0;
    endtask

    task automatic pix(input int idx, input int x, input int y);
        PaletteIndex = 4'(idx); DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1;
    endtask

    task automatic frame();
        frame_start = 1; step(); frame_start = 0; step();
    endtask

    typedef struct {
        int          idx;
        int          x;
        int          y;
        logic        v;
        logic [23:0] rgb;
    } vec_t;

    vec_t tab [7];

    initial begin
        tab[0] = '{3, 5, 5, 1'b1, 24'h079CC2};
        tab[1] = '{0, 8, 3, 1'b1, 24'hE7CAA0};
        tab[2] = '{0, 9, 3, 1'b1, 24'hFAF7EB};
        tab[3] = '{12, 1, 1, 1'b1, 24'h000000};
        tab[4] = '{3, 5, 5, 1'b0, 24'h000000};
        tab[5] = '{0, 9, 16, 1'b1, 24'hE7CAA0};
        tab[6] = '{9, 0, 0, 1'b1, 24'hFAF7EB};

        set_idle();
        Reset_n = 0;
        step(); step();
        chk("rst_level", 32'(fade_level), 32'd16);
        chk("rst_out", {7'd0, out_valid, VGA_R, VGA_G, VGA_B}, 32'd0);
        Reset_n = 1;

        for (int i = 0; i < 7; i++) begin
            set_idle();
            pix(tab[i].idx, tab[i].x, tab[i].y);
            pix_valid = tab[i].v;
            step();
            set_idle();
            step();
            chk("table", {7'd0, out_valid, VGA_R, VGA_G, VGA_B}, {7'd0, tab[i].v, tab[i].rgb});
        end

        // Write entry 4 while reading it: old value first, new value next
        set_idle(); pix(4, 1, 1); pal_we = 1; pal_waddr = 4; pal_wdata = 24'h102030;
        step();
        set_idle(); pix(4, 1, 1);
        step();
        chk("wr_old", {8'd0, VGA_R, VGA_G, VGA_B}, 32'hC7C42B);
        set_idle();
        step();
        chk("wr_new", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h102030);

        // Grid colour rewrite
        set_idle(); grid_we = 1; pal_wdata = 24'h123456;
        step();
        set_idle(); pix(0, 16, 5); step();
        set_idle(); pix(0, 9, 9); step();
        chk("grid_new", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h123456);
        set_idle(); step();
        chk("grid_off", {8'd0, VGA_R, VGA_G, VGA_B}, 32'hFAF7EB);

        // Fade out over 16 frames
        set_idle(); fade_start = 1; fade_dir = 0; step();
        set_idle();
        chk("fo_start", {26'd0, fade_busy, fade_level}, {26'd0, 1'b1, 5'd16});
        for (int f = 1; f <= 16; f++) begin
            frame();
            chk("fo_level", 32'(fade_level), 32'(16 - f));
            if (f == 8) begin
                pix(7, 3, 3); step(); set_idle(); step();
                chk("lvl8_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 32'h7E743E);
            end
        end
        chk("fo_done", {26'd0, fade_busy, fade_level}, 32'd0);
        pix(7, 3, 3); step(); set_idle(); step();
        chk("dark_rgb", {7'd0, out_valid, VGA_R, VGA_G, VGA_B}, 32'h01000000);

        // DARK ignores a fade-out request, accepts fade-in
        fade_start = 1; fade_dir = 0; step(); set_idle(); step();
        chk("dark_ign", {26'd0, fade_busy, fade_level}, 32'd0);
        fade_start = 1; fade_dir = 1; step(); set_idle();
        chk("fi_start", {26'd0, fade_busy, fade_level}, {26'd0, 1'b1, 5'd0});
        for (int f = 1; f <= 16; f++) begin
            frame();
            if (f == 5) begin
                fade_start = 1; fade_dir = 0; step(); set_idle();
                chk("fi_ign", {26'd0, fade_busy, fade_level}, {26'd0, 1'b1, 5'd5});
            end
        end
        chk("fi_done", {26'd0, fade_busy, fade_level}, {26'd0, 1'b0, 5'd16});

        // Fade-in from IDLE completes on the next frame with no change
        fade_start = 1; fade_dir = 1; step(); set_idle();
        chk("idle_fi", {26'd0, fade_busy, fade_level}, {26'd0, 1'b1, 5'd16});
        frame();
        chk("idle_fi_end", {26'd0, fade_busy, fade_level}, {26'd0, 1'b0, 5'd16});

        // Start coincident with frame_start, then reset mid-fade
        fade_start = 1; fade_dir = 0; frame_start = 1; step(); set_idle();
        chk("start_frame", {26'd0, fade_busy, fade_level}, {26'd0, 1'b1, 5'd16});
        frame(); frame(); frame();
        chk("mid_level", 32'(fade_level), 32'd13);
        Reset_n = 0; step(); Reset_n = 1;
        chk("rst_mid", {26'd0, fade_busy, fade_level}, {26'd0, 1'b0, 5'd16});
        pix(4, 1, 1); step(); set_idle(); step();
        chk("rst_pal", {8'd0, VGA_R, VGA_G, VGA_B}, 32'hC7C42B);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            Reset_n      = ($urandom_range(0, 599) != 0);
            pix_valid    = ($urandom_range(0, 7) != 0);
            PaletteIndex = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            DrawX        = 10'($urandom);
            DrawY        = 10'($urandom);
            frame_start  = ($urandom_range(0, 3) == 0);
            fade_start   = ($urandom_range(0, 19) == 0);
            fade_dir     = 1'($urandom);
            pal_we       = ($urandom_range(0, 7) == 0);
            grid_we      = ($urandom_range(0, 15) == 0);
            pal_waddr    = 4'($urandom);
            pal_wdata    = 24'($urandom);
            step();
        end
        Reset_n = 1;
        set_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/palette_mapper_pipe.md
Name: palette_mapper_pipe

Overview:
- Pipelined, programmable successor to the fixed-table palette colour mapper; sits between the sprite/background index mux and the VGA DAC outputs.
- Palette held in a writable register file, reset-loaded with the game's standard colours.
- Index 0 keeps the background-with-grid behaviour, with programmable grid pitch and colour.
- Adds a frame-synchronous fade-out/fade-in brightness engine for game-over and restart transitions.

Parameters:
- INDEX_W, 4, width of PaletteIndex; the palette has 2**INDEX_W entries.
- COLOR_W, 8, bits per colour channel.
- GRID_LOG2, 3, grid pitch is 2**GRID_LOG2 pixels.
- FADE_W, 4, fade resolution; the brightness level runs 0..2**FADE_W.

Ports:
- Clk  in  1  system clock; all logic rising-edge.
- Reset_n  in  1  synchronous, active-low reset.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- PaletteIndex  in  INDEX_W  colour index for the current pixel.
- pix_valid  in  1  DrawX/DrawY/PaletteIndex valid this cycle.
- frame_start  in  1  one-cycle pulse per frame (vsync edge); paces the fade engine.
- pal_we  in  1  palette write strobe.
- pal_waddr  in  INDEX_W  palette entry to write.
- pal_wdata  in  3*COLOR_W  {R,G,B} value to write.
- grid_we  in  1  grid colour write strobe; uses pal_wdata.
- fade_start  in  1  one-cycle request to begin a fade.
- fade_dir  in  1  direction sampled with fade_start: 0 = fade out, 1 = fade in.
- fade_busy  out  1  high while a fade is in progress.
- fade_level  out  FADE_W+1  current brightness level.
- VGA_R  out  COLOR_W  red output.
- VGA_G  out  COLOR_W  green output.
- VGA_B  out  COLOR_W  blue output.
- out_valid  out  1  pix_valid delayed to align with the RGB outputs.

Behaviour:
- Reset (Reset_n low at an edge) sets the following:
  - VGA_R/G/B = 0, out_valid = 0.
  - Fade engine in IDLE; fade_level = 2**FADE_W (full brightness); fade_busy = 0.
  - Pipeline registers cleared.
  - Grid colour = {231,202,160}.
  - Palette entries set to:
    - 0: {250,247,235}
    - 1: {00,00,00}
    - 2: {26,26,26}h
    - 3: {07,9C,C2}h
    - 4: {C7,C4,2B}h
    - 5: {5B,8C,20}h
    - 6: {59,59,59}h
    - 7: {FD,E8,7D}h
    - 8: {48,92,6A}h
    - 9: {250,247,235}
    - all remaining entries: 0.
- Pipeline, fixed 2-cycle latency from input to outputs; no stalls.
- Stage 1 (registered):
  - Palette read of PaletteIndex.
  - grid_hit = (PaletteIndex == 0) and (the low GRID_LOG2 bits of DrawX are 0, or the low GRID_LOG2 bits of DrawY are 0).
  - On grid_hit the grid colour replaces the palette colour.
  - pix_valid is registered alongside.
- Stage 2 (registered): each channel = (c * fade_level) >> FADE_W.
  - Product width COLOR_W+FADE_W+1; truncate after the shift.
  - At level 2**FADE_W the output equals c exactly; at level 0 the output is 0.
- When out_valid = 0, RGB outputs are forced to 0 (blanking).
- Palette write (pal_we) takes effect at the clock edge.
  - A read of the same entry in that cycle returns the OLD value.
  - The new value is visible to pixels presented on the following cycle.
  - grid_we behaves the same way.
  - pal_we and grid_we in the same cycle: both writes are performed.
- Fade FSM states: IDLE, FADE_OUT, DARK, FADE_IN.
- IDLE:
  - fade_start with fade_dir = 0 -> FADE_OUT.
  - fade_start with fade_dir = 1 -> FADE_IN.
- DARK:
  - fade_start with fade_dir = 1 -> FADE_IN.
  - fade_start with fade_dir = 0 is ignored.
- FADE_OUT: on each frame_start, level decrements by 1; the edge where level reaches 0 also moves the state to DARK.
- FADE_IN: on each frame_start, level increments by 1; the edge where level reaches 2**FADE_W also moves the state to IDLE.
- fade_start while in FADE_OUT or FADE_IN is ignored; no restart or reversal.
- FADE_IN from IDLE starts at the current level (already max), so it completes on the next frame_start with no change.
- frame_start in the same cycle as fade_start: the state transitions only; the level changes from the next frame_start.
- Level saturates; it never wraps below 0 or above 2**FADE_W.
- fade_busy = 1 exactly in FADE_OUT and FADE_IN.
- The level change is seen by the stage-2 multiply of the following cycle.
- Reset mid-fade: immediate return to IDLE at full level; palette contents revert to the reset table.

Test Plan:
- Reset, then PaletteIndex=3, DrawX=5, DrawY=5, pix_valid=1 -> two cycles later RGB = {07,9C,C2}h, out_valid = 1.
- Index 0 at (8,3) -> {231,202,160}; index 0 at (9,3) -> {250,247,235}; index 12 -> {0,0,0}; pix_valid=0 -> RGB 0, out_valid 0.
- Write entry 4 = {10,20,30}h while reading index 4 in the same cycle -> that pixel outputs {C7,C4,2B}h; the next pixel outputs {10,20,30}h.
- Write the grid colour, then check that index 0 on grid lines uses the new value and off-grid index 0 is unchanged.
- fade_start with fade_dir=0, then 16 frame_start pulses:
  - fade_level steps 16 -> 0; fade_busy drops after the 16th pulse; state is DARK.
  - Index 7 gives {00,00,00}.
  - At level 8, index 7 gives {7E,74,3E}h.
- In DARK, fade_start with fade_dir=0 is ignored; fade_start with fade_dir=1 then 16 frames returns to level 16 and IDLE; fade_start during the fade is ignored; Reset_n low mid-fade -> level 16, fade_busy 0, palette reverts to the reset table.
